// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches words over a req/ack memory port and
// hands them to decode over valid/ready, applying downstream redirects.
module instruction_fetch #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      opCode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misaligned,
    output logic [31:0]     instr_count,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t          state, state_next;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     instr_next;
    logic            misaligned_next;
    logic [31:0]     count_next;
    logic            accept;

    // Handshake: a transfer happens on a rising edge where instr_valid and
    // instr_ready are both high; once valid rises, instr/opCode/pc stay fixed
    // until that edge. redirect/redirect_target are only sampled on a transfer.
    assign imem_req    = (state == WAIT);
    assign instr_valid = (state == HOLD);
    assign accept      = instr_valid & instr_ready;
    assign imem_addr   = pc;
    assign pc_plus4    = pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign opCode      = instr[6:0];
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= NOP;
            misaligned  <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            misaligned  <= misaligned_next;
            instr_count <= count_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_next      = instr;
        misaligned_next = misaligned;
        count_next      = instr_count;
        case (state)
            IDLE: state_next = WAIT;
            WAIT: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    count_next = instr_count + 32'd1;
                    if (!redirect) begin
                        pc_next    = pc_plus4;
                        state_next = WAIT;
                    end else if (redirect_target[1:0] == 2'b00) begin
                        pc_next    = redirect_target;
                        state_next = WAIT;
                    end else begin
                        // Faulting target: keep the PC of the offending instruction.
                        misaligned_next = 1'b1;
                        state_next      = HALT;
                    end
                end
            end
            HALT: misaligned_next = 1'b1;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, backpressure,
// redirect, misaligned halt, reset mid-WAIT and PC wrap.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opCode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        misaligned;
    logic [31:0] instr_count;
    logic [1:0]  dbg_state;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [6:0]  w_opCode;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_misaligned;
    logic [31:0] w_instr_count;
    logic [1:0]  w_dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   mem_word = 32'h0050_0093;
            32'h4:   mem_word = 32'h00A0_0113;
            32'h8:   mem_word = 32'h0020_81B3;
            default: mem_word = {addr[24:0], 7'h33};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instruction_fetch u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opCode(opCode), .pc(pc), .pc_plus4(pc_plus4),
        .redirect(redirect), .redirect_target(redirect_target),
        .misaligned(misaligned), .instr_count(instr_count),
        .dbg_state(dbg_state)
    );

    instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr(w_instr), .opCode(w_opCode), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .redirect(redirect), .redirect_target(redirect_target),
        .misaligned(w_misaligned), .instr_count(w_instr_count),
        .dbg_state(w_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_delivered(input string tag, input logic [31:0] exp_pc);
        logic [31:0] exp_instr;
        exp_instr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_opcode"}, {25'd0, opCode}, {25'd0, exp_instr[6:0]});
    endtask

    initial begin
        exp_q.push_back(32'h0050_0093);
        exp_q.push_back(32'h00A0_0113);
        exp_q.push_back(32'h0020_81B3);
        exp_q.push_back(32'h0000_0633);
        exp_q.push_back(32'h0000_0833);
        exp_q.push_back(32'h0000_2033);
        exp_q.push_back(32'h0050_0093);

        reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_target = 32'h0;
        step(); step();

        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc",    pc, 32'h0);
        check("rst_pc4",   pc_plus4, 32'h4);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_opcode", {25'd0, opCode}, 32'h13);
        check("rst_misal", {31'd0, misaligned}, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("wrap_rst_pc",  w_pc, 32'hFFFF_FFFC);
        check("wrap_rst_pc4", w_pc_plus4, 32'h0);

        // Sequential fetch with zero-wait memory.
        reset = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
        step();
        check("seq0_req",   {31'd0, imem_req}, 32'd1);
        check("seq0_addr",  imem_addr, 32'h0);
        check("seq0_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check_delivered("seq0", 32'h0);
        step();
        check("seq1_addr",  imem_addr, 32'h4);
        check("seq1_count", instr_count, 32'd1);
        check("wrap_pc",    w_pc, 32'h0);
        check("wrap_count", w_instr_count, 32'd1);

        // Memory stall: three cycles without ack at 0x4.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req",   {31'd0, imem_req}, 32'd1);
            check("stall_addr",  imem_addr, 32'h4);
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b1;
        step();
        check_delivered("seq1", 32'h4);
        check("seq1_cnt_hold", instr_count, 32'd1);
        step();
        check("seq2_addr", imem_addr, 32'h8);

        // Backpressure at 0x8; redirect while not accepted must be ignored.
        instr_ready = 1'b0;
        step();
        check_delivered("seq2", 32'h8);
        redirect = 1'b1; redirect_target = 32'h40;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_req",   {31'd0, imem_req}, 32'd0);
            check("bp_pc",    pc, 32'h8);
            check("bp_instr", instr, 32'h0020_81B3);
            check("bp_count", instr_count, 32'd2);
        end
        redirect = 1'b0; instr_ready = 1'b1;
        step();
        check("bp_pc_after", pc, 32'hC);
        check("seq_count3",  instr_count, 32'd3);
        check("bp_req_after", {31'd0, imem_req}, 32'd1);
        step();
        check_delivered("pc_c", 32'hC);
        step();
        check("addr_10", imem_addr, 32'h10);
        step();
        check_delivered("pc_10", 32'h10);

        // Aligned redirect.
        redirect = 1'b1; redirect_target = 32'h40;
        step();
        check("redir_addr",  imem_addr, 32'h40);
        check("redir_pc4",   pc_plus4, 32'h44);
        check("redir_req",   {31'd0, imem_req}, 32'd1);
        check("redir_count", instr_count, 32'd5);
        redirect = 1'b0;
        step();
        check_delivered("pc_40", 32'h40);

        // Misaligned redirect halts until reset; ack stays high and is ignored.
        redirect = 1'b1; redirect_target = 32'h42;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("halt_misal", {31'd0, misaligned}, 32'd1);
            check("halt_req",   {31'd0, imem_req}, 32'd0);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_pc",    pc, 32'h40);
            check("halt_count", instr_count, 32'd6);
            check("halt_state", {30'd0, dbg_state}, 32'd3);
            step();
        end

        reset = 1'b1;
        step();
        check("halt_rst_misal", {31'd0, misaligned}, 32'd0);
        check("halt_rst_pc",    pc, 32'h0);
        check("halt_rst_count", instr_count, 32'd0);

        // Reset while a request is outstanding, with ack in the reset cycle.
        reset = 1'b0; imem_ack = 1'b0;
        step();
        step();
        check("midwait_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1; imem_ack = 1'b1;
        step();
        check("midwait_rst_req",   {31'd0, imem_req}, 32'd0);
        check("midwait_rst_pc",    pc, 32'h0);
        check("midwait_rst_instr", instr, 32'h0000_0013);
        check("midwait_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("midwait_rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        step();
        step();
        check_delivered("restart", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
